hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 124 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard with per-GPR latency counters and a fetch-cancel FSM.
// Optional macro HAZARD_CSR_SERIAL_EN serialises CSR-class instructions behind an in-flight flag.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int SRC_NUM  = 3,
  parameter int LAT_W    = 3
) (
  input  logic                     aclk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [SRC_NUM*REG_W-1:0] id_src_reg,
  input  logic [SRC_NUM-1:0]       id_src_en,
  input  logic                     id_dst_en,
  input  logic [REG_W-1:0]         id_dst_reg,
  input  logic [LAT_W-1:0]         id_dst_lat,
  input  logic                     id_is_csr,
  input  logic                     csr_retire,
  input  logic                     ex_allow_in,
  input  logic                     pipe_flush,
  input  logic                     branch_redirect,
  input  logic                     if_req_outstanding,
  input  logic                     if_resp_valid,
  output logic                     stall,
  output logic                     issue_fire,
  output logic                     if_resp_cancel,
  output logic                     cancel_pending,
  output logic [NUM_REGS-1:0]      busy_mask
);

  typedef enum logic {IDLE = 1'b0, CANCEL = 1'b1} fc_state_e;

  // Handshake: an instruction leaves ID exactly when issue_fire is high, i.e. it is
  // valid, hazard-free, EX accepts it (ex_allow_in) and no flush is killing it.

  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];
  fc_state_e        state_q, state_d;
  logic             raw_hazard;
  logic             csr_block;
  logic             redirect;
  logic [REG_W-1:0] src_idx;

  always_comb begin
    raw_hazard = 1'b0;
    src_idx    = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      src_idx = id_src_reg[i*REG_W +: REG_W];
      if (id_src_en[i] && (src_idx != '0) && (cnt_q[src_idx] != '0)) raw_hazard = 1'b1;
    end
  end

`ifdef HAZARD_CSR_SERIAL_EN
  logic csr_inflight_q, csr_inflight_d;

  // Retire (or flush) beats a same-cycle CSR issue so the flag never sticks.
  always_comb begin
    csr_inflight_d = csr_inflight_q;
    if (issue_fire && id_is_csr) csr_inflight_d = 1'b1;
    if (csr_retire || pipe_flush) csr_inflight_d = 1'b0;
  end

  always_ff @(posedge aclk) begin
    if (reset) csr_inflight_q <= 1'b0;
    else       csr_inflight_q <= csr_inflight_d;
  end

  assign csr_block = csr_inflight_q;
`else
  logic unused_csr;
  assign unused_csr = id_is_csr ^ csr_retire;
  assign csr_block  = 1'b0;
`endif

  assign stall      = id_valid & (raw_hazard | csr_block);
  assign issue_fire = id_valid & ~stall & ex_allow_in & ~pipe_flush;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      if (issue_fire && id_dst_en && (id_dst_reg != '0) && (id_dst_reg == REG_W'(r)))
        cnt_d[r] = id_dst_lat;
      if (pipe_flush) cnt_d[r] = '0;
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NUM_REGS; r++) busy_mask[r] = (cnt_q[r] != '0);
  end

  assign redirect = branch_redirect | pipe_flush;

  // A redirect that lands with the response itself keeps that response; only a
  // response still in flight at redirect time is dropped.
  always_comb begin
    state_d        = state_q;
    if_resp_cancel = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect && if_req_outstanding && !if_resp_valid) state_d = CANCEL;
      end
      CANCEL: begin
        if_resp_cancel = if_resp_valid;
        if (if_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cancel_pending = (state_q == CANCEL);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; honours HAZARD_CSR_SERIAL_EN
// to pick the expected CSR-serialisation behaviour.
module tb_hazard_scoreboard;

`ifdef HAZARD_CSR_SERIAL_EN
  localparam bit CSR_EN = 1'b1;
`else
  localparam bit CSR_EN = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [14:0] id_src_reg;
  logic [2:0]  id_src_en;
  logic        id_dst_en;
  logic [4:0]  id_dst_reg;
  logic [2:0]  id_dst_lat;
  logic        id_is_csr, csr_retire, ex_allow_in, pipe_flush, branch_redirect;
  logic        if_req_outstanding, if_resp_valid;
  logic        stall, issue_fire, if_resp_cancel, cancel_pending;
  logic [31:0] busy_mask;

  int n_cmp = 0;
  int n_err = 0;

  hazard_scoreboard dut (
    .aclk(aclk), .reset(reset), .id_valid(id_valid), .id_src_reg(id_src_reg),
    .id_src_en(id_src_en), .id_dst_en(id_dst_en), .id_dst_reg(id_dst_reg),
    .id_dst_lat(id_dst_lat), .id_is_csr(id_is_csr), .csr_retire(csr_retire),
    .ex_allow_in(ex_allow_in), .pipe_flush(pipe_flush), .branch_redirect(branch_redirect),
    .if_req_outstanding(if_req_outstanding), .if_resp_valid(if_resp_valid),
    .stall(stall), .issue_fire(issue_fire), .if_resp_cancel(if_resp_cancel),
    .cancel_pending(cancel_pending), .busy_mask(busy_mask)
  );

  // Clock / reset block
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_src_reg = '0; id_src_en = '0; id_dst_en = 0; id_dst_reg = '0;
    id_dst_lat = '0; id_is_csr = 0; csr_retire = 0; ex_allow_in = 1; pipe_flush = 0;
    branch_redirect = 0; if_req_outstanding = 0; if_resp_valid = 0;
  endtask

  task automatic drive_issue(input logic [4:0] dst, input logic [2:0] lat);
    idle_inputs();
    id_valid = 1; id_dst_en = 1; id_dst_reg = dst; id_dst_lat = lat;
  endtask

  task automatic drive_use(input int slot, input logic [4:0] src);
    idle_inputs();
    id_valid = 1;
    id_src_en[slot] = 1'b1;
    id_src_reg[slot*5 +: 5] = src;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    // Junk on the inputs during reset must not leak out.
    id_valid = 1; id_src_en = 3'b001; id_src_reg = 15'd5; id_dst_en = 1; id_dst_reg = 5'd5;
    id_dst_lat = 3'd7; branch_redirect = 1; if_req_outstanding = 1; if_resp_valid = 1;
    tick(); tick();
    check_eq("rst_busy", busy_mask, 32'h0);
    check_eq("rst_cancel_pending", {31'b0, cancel_pending}, 32'd0);
    check_eq("rst_resp_cancel", {31'b0, if_resp_cancel}, 32'd0);
    check_eq("rst_stall", {31'b0, stall}, 32'd0);
    reset = 0; idle_inputs(); tick();

    // Load-use: r5 with lat 2 holds a consumer while its counter is nonzero.
    drive_issue(5'd5, 3'd2); #1;
    check_eq("lu_issue", {31'b0, issue_fire}, 32'd1);
    tick();
    drive_use(0, 5'd5); #1;
    check_eq("lu_busy", busy_mask, 32'h0000_0020);
    check_eq("lu_stall1", {31'b0, stall}, 32'd1);
    check_eq("lu_nofire1", {31'b0, issue_fire}, 32'd0);
    tick(); #1;
    check_eq("lu_stall2", {31'b0, stall}, 32'd1);
    tick(); #1;
    check_eq("lu_stall3", {31'b0, stall}, 32'd0);
    check_eq("lu_fire", {31'b0, issue_fire}, 32'd1);
    tick();

    // Operand slot 2 and its enable.
    drive_issue(5'd9, 3'd3); tick();
    drive_use(2, 5'd9); #1;
    check_eq("slot2_stall", {31'b0, stall}, 32'd1);
    id_src_en = 3'b000; #1;
    check_eq("slot2_disabled", {31'b0, stall}, 32'd0);
    idle_inputs(); tick(); tick(); tick(); #1;
    check_eq("drain_busy", busy_mask, 32'h0);

    // WAW: newer lat-0 writer overrides the pending lat-3 one.
    drive_issue(5'd7, 3'd3); tick();
    drive_issue(5'd7, 3'd0); #1;
    check_eq("waw_busy_mid", busy_mask, 32'h0000_0080);
    check_eq("waw_fire2", {31'b0, issue_fire}, 32'd1);
    tick();
    drive_use(1, 5'd7); #1;
    check_eq("waw_busy", busy_mask, 32'h0);
    check_eq("waw_nostall", {31'b0, stall}, 32'd0);
    tick();

    // r0 is never busy.
    drive_issue(5'd0, 3'd7); tick();
    drive_use(0, 5'd0); #1;
    check_eq("r0_busy", busy_mask, 32'h0);
    check_eq("r0_stall", {31'b0, stall}, 32'd0);
    tick();

    // EX not accepting: no issue, no counter load.
    drive_issue(5'd12, 3'd4); ex_allow_in = 0; #1;
    check_eq("noallow_fire", {31'b0, issue_fire}, 32'd0);
    tick(); idle_inputs(); #1;
    check_eq("noallow_busy", busy_mask, 32'h0);

    // Flush with r3=4, r9=2 pending.
    drive_issue(5'd3, 3'd5); tick();
    drive_issue(5'd9, 3'd2); tick();
    idle_inputs(); #1;
    check_eq("fl_busy_pre", busy_mask, 32'h0000_0208);
    drive_issue(5'd4, 3'd3); pipe_flush = 1; #1;
    check_eq("fl_fire", {31'b0, issue_fire}, 32'd0);
    tick(); idle_inputs(); #1;
    check_eq("fl_busy_post", busy_mask, 32'h0);

    // Fetch cancel: response arrives 3 cycles after redirect.
    branch_redirect = 1; if_req_outstanding = 1; #1;
    check_eq("fc_idle_nocancel", {31'b0, if_resp_cancel}, 32'd0);
    tick(); idle_inputs(); if_req_outstanding = 1; #1;
    check_eq("fc_pending1", {31'b0, cancel_pending}, 32'd1);
    branch_redirect = 1; tick(); branch_redirect = 0; #1;
    check_eq("fc_pending2", {31'b0, cancel_pending}, 32'd1);
    check_eq("fc_nocancel2", {31'b0, if_resp_cancel}, 32'd0);
    tick();
    if_resp_valid = 1; #1;
    check_eq("fc_cancel", {31'b0, if_resp_cancel}, 32'd1);
    tick(); #1;
    check_eq("fc_back_idle", {31'b0, cancel_pending}, 32'd0);
    check_eq("fc_keep_next", {31'b0, if_resp_cancel}, 32'd0);
    idle_inputs();
    // Redirect coinciding with the response stays IDLE.
    branch_redirect = 1; if_req_outstanding = 1; if_resp_valid = 1; tick(); idle_inputs(); #1;
    check_eq("fc_coincide", {31'b0, cancel_pending}, 32'd0);
    // Flush also counts as a redirect; reset wins mid-CANCEL.
    pipe_flush = 1; if_req_outstanding = 1; tick(); idle_inputs(); #1;
    check_eq("fc_flush_enter", {31'b0, cancel_pending}, 32'd1);
    reset = 1; tick(); reset = 0; if_resp_valid = 1; #1;
    check_eq("fc_rst_mid", {31'b0, cancel_pending}, 32'd0);
    check_eq("fc_rst_nocancel", {31'b0, if_resp_cancel}, 32'd0);
    idle_inputs(); tick();

    // CSR serialisation.
    id_valid = 1; id_is_csr = 1; #1;
    check_eq("csr_issue", {31'b0, issue_fire}, 32'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive_issue(5'(k + 10), 3'd0); #1;
      check_eq("csr_follow_stall", {31'b0, stall}, {31'b0, CSR_EN});
      check_eq("csr_follow_fire", {31'b0, issue_fire}, {31'b0, ~CSR_EN});
      tick();
    end
    drive_issue(5'd20, 3'd0); csr_retire = 1; #1;
    check_eq("csr_retire_stall", {31'b0, stall}, {31'b0, CSR_EN});
    tick(); csr_retire = 0; #1;
    check_eq("csr_resume", {31'b0, issue_fire}, 32'd1);
    tick();
    idle_inputs(); id_valid = 1; id_is_csr = 1; csr_retire = 1; tick();
    idle_inputs(); id_valid = 1; #1;
    check_eq("csr_retire_wins", {31'b0, stall}, 32'd0);
    id_is_csr = 1; tick();
    idle_inputs(); pipe_flush = 1; tick();
    idle_inputs(); id_valid = 1; #1;
    check_eq("csr_flush_clears", {31'b0, stall}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
